// File: rtl/rr_arb8_ctrl_pkg.sv
// rr_arb_pkg: shared constants and FSM encoding for the eight-way round-robin arbiter
package rr_arb_pkg;
  localparam int N = 8;
  localparam int IDX_W = 3;
  localparam int TIMEOUT_DEF = 15;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
endpackage

// File: rtl/rr_arb8_ctrl_seg.sv
// seg: seven-segment decoder for a 3-bit index
//   val in  3  digit to show
//   pat out 8  active-high segments {dp,g,f,e,d,c,b,a}
module seg (
  input  logic [2:0] val,
  output logic [7:0] pat
);
  always_comb
    pat = val == 3'd0 ? 8'h3F :
          val == 3'd1 ? 8'h06 :
          val == 3'd2 ? 8'h5B :
          val == 3'd3 ? 8'h4F :
          val == 3'd4 ? 8'h66 :
          val == 3'd5 ? 8'h6D :
          val == 3'd6 ? 8'h7D : 8'h07;
endmodule

// File: rtl/rr_arb8_ctrl.sv
// rr_arb8_ctrl: eight-way round-robin arbiter with grant index on a seven-segment display
//   i_clk in 1, i_rst in 1 (sync, active high), i_req in 8
//   o_gnt out 8 one-hot, o_gnt_idx out 3, o_gnt_vld out 1, o_timeout out 1, o_seg out 8
//   RR_ARB_TIMEOUT_EN: when defined, a grant held TIMEOUT cycles is revoked if others wait
module rr_arb8_ctrl
  import rr_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N-1:0]     i_req,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_gnt_vld,
  output logic             o_timeout,
  output logic [7:0]       o_seg
);
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be >= 1");
  end
  // first set bit at or above 'from', wrapping; msb of result flags a hit
  function automatic logic [IDX_W:0] pick(input logic [N-1:0] req, input logic [IDX_W-1:0] from);
    logic [N-1:0] rot;
    logic [IDX_W:0] r;
    rot = N'({req, req} >> from);
    r = '0;
    for (int i = N-1; i >= 0; i--) if (rot[i]) r = {1'b1, from + IDX_W'(i)};
    return r;
  endfunction
  state_t state, state_n;
  logic [N-1:0] gnt, gnt_n, others;
  logic [IDX_W-1:0] idx, idx_n, ptr, ptr_n;
  logic [IDX_W:0] p_idle, p_rel;
  logic own, rotate;
  assign own = i_req[idx];
  assign others = i_req & ~(N'(1) << idx);
  assign p_idle = pick(i_req, ptr);
  assign p_rel = pick(others, idx + IDX_W'(1));
`ifdef RR_ARB_TIMEOUT_EN
  localparam int HW = $clog2(TIMEOUT + 1);
  logic [HW-1:0] hold, hold_n;
  logic expire, to, to_n;
  assign expire = hold == HW'(TIMEOUT);
  assign rotate = !own || (expire && |others);
  assign o_timeout = to;
`else
  assign rotate = !own;
  assign o_timeout = 1'b0;
`endif
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    idx_n = idx;
    ptr_n = ptr;
`ifdef RR_ARB_TIMEOUT_EN
    hold_n = (state == GRANT && !expire) ? hold + HW'(1) : '0;
    to_n = 1'b0;
`endif
    if (state == IDLE) begin
      if (p_idle[IDX_W]) begin
        state_n = GRANT;
        idx_n = p_idle[IDX_W-1:0];
        gnt_n = N'(1) << p_idle[IDX_W-1:0];
`ifdef RR_ARB_TIMEOUT_EN
        hold_n = '0;
`endif
      end
    end else if (rotate) begin
      ptr_n = idx + IDX_W'(1);
      if (p_rel[IDX_W]) begin
        idx_n = p_rel[IDX_W-1:0];
        gnt_n = N'(1) << p_rel[IDX_W-1:0];
`ifdef RR_ARB_TIMEOUT_EN
        hold_n = '0;
        to_n = own;
`endif
      end else begin
        state_n = IDLE;
        gnt_n = '0;
      end
    end
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= IDLE;
      gnt <= '0;
      idx <= '0;
      ptr <= '0;
`ifdef RR_ARB_TIMEOUT_EN
      hold <= '0;
      to <= 1'b0;
`endif
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      idx <= idx_n;
      ptr <= ptr_n;
`ifdef RR_ARB_TIMEOUT_EN
      hold <= hold_n;
      to <= to_n;
`endif
    end
  assign o_gnt = gnt;
  assign o_gnt_idx = idx;
  assign o_gnt_vld = |gnt;
  seg u_seg (.val(idx), .pat(o_seg));
endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// tb_rr_arb8_ctrl: directed table-driven check of rr_arb8_ctrl
module tb_rr_arb8_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt, seg_pat;
  logic [2:0] gidx;
  logic vld, tmo;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  rr_arb8_ctrl #(.TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_gnt(gnt), .o_gnt_idx(gidx),
    .o_gnt_vld(vld), .o_timeout(tmo), .o_seg(seg_pat)
  );
  typedef struct {
    logic rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
  } vec_t;
  logic [7:0] seg_tab [8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};
  task automatic chk(input string name, input int step, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h want %h", name, step, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_all(input int step, input logic [7:0] eg, input logic [2:0] ei, input logic et);
    chk("gnt", step, gnt, eg);
    chk("idx", step, {5'd0, gidx}, {5'd0, ei});
    chk("vld", step, {7'd0, vld}, {7'd0, eg != 8'h00});
    chk("seg", step, seg_pat, seg_tab[ei]);
    chk("timeout", step, {7'd0, tmo}, {7'd0, et});
  endtask
  vec_t tv [$];
  initial begin
    tv.push_back('{1'b1, 8'hFF, 8'h00, 3'd0});
    tv.push_back('{1'b1, 8'hFF, 8'h00, 3'd0});
    tv.push_back('{1'b0, 8'hFF, 8'h01, 3'd0});
    tv.push_back('{1'b0, 8'hFE, 8'h02, 3'd1});
    tv.push_back('{1'b0, 8'hFD, 8'h04, 3'd2});
    tv.push_back('{1'b0, 8'hFB, 8'h08, 3'd3});
    tv.push_back('{1'b0, 8'hF7, 8'h10, 3'd4});
    tv.push_back('{1'b0, 8'hEF, 8'h20, 3'd5});
    tv.push_back('{1'b0, 8'hDF, 8'h40, 3'd6});
    tv.push_back('{1'b0, 8'hBF, 8'h80, 3'd7});
    tv.push_back('{1'b0, 8'h7F, 8'h01, 3'd0});
    tv.push_back('{1'b0, 8'hFF, 8'h01, 3'd0});
    tv.push_back('{1'b0, 8'h20, 8'h20, 3'd5});
    tv.push_back('{1'b0, 8'h61, 8'h20, 3'd5});
    tv.push_back('{1'b0, 8'h41, 8'h40, 3'd6});
    tv.push_back('{1'b0, 8'h84, 8'h80, 3'd7});
    tv.push_back('{1'b0, 8'h84, 8'h80, 3'd7});
    tv.push_back('{1'b0, 8'h04, 8'h04, 3'd2});
    tv.push_back('{1'b0, 8'h00, 8'h00, 3'd2});
    tv.push_back('{1'b0, 8'h00, 8'h00, 3'd2});
    tv.push_back('{1'b0, 8'h04, 8'h04, 3'd2});
    tv.push_back('{1'b0, 8'h10, 8'h10, 3'd4});
    tv.push_back('{1'b1, 8'h10, 8'h00, 3'd0});
    tv.push_back('{1'b0, 8'hFF, 8'h01, 3'd0});
    tv.push_back('{1'b0, 8'hFE, 8'h02, 3'd1});
    #1;
    foreach (tv[i]) begin
      rst = tv[i].rst;
      req = tv[i].req;
      tick();
      chk_all(i, tv[i].gnt, tv[i].idx, 1'b0);
    end
    // owner 1 holds with 3 waiting
    rst = 1'b1;
    req = 8'h0A;
    tick();
    rst = 1'b0;
    tick();
    chk_all(100, 8'h02, 3'd1, 1'b0);
`ifdef RR_ARB_TIMEOUT_EN
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_all(100 + i, 8'h02, 3'd1, 1'b0);
    end
    tick();
    chk_all(105, 8'h08, 3'd3, 1'b1);
    tick();
    chk_all(106, 8'h08, 3'd3, 1'b0);
    // lone requester is never revoked
    rst = 1'b1;
    req = 8'h02;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_all(200 + i, 8'h02, 3'd1, 1'b0);
    end
`else
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk_all(100 + i, 8'h02, 3'd1, 1'b0);
    end
    req = 8'h08;
    tick();
    chk_all(121, 8'h08, 3'd3, 1'b0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rr_arb8_ctrl.md
# rr_arb8_ctrl

Eight-way round-robin arbiter that shares one downstream resource among eight requesters and shows the current owner's index on the seven-segment display. Each requester holds its request line high for as long as it needs the resource. The controller issues a registered one-hot grant plus a 3-bit grant index. That index drives the existing `seg` decoder, so the display always shows the active owner.

## Interface
Parameters:
- `N`, 8, number of requesters; fixed at 8 in this revision.
- `IDX_W`, 3, grant index width; equals $clog2(N).
- `TIMEOUT`, 15, maximum grant hold in cycles before forced rotation. Must be ≥ 1. Used only when `RR_ARB_TIMEOUT_EN` is defined.

Ports:
- `i_clk`  in  1  sole clock; all state updates on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_req`  in  8  request vector; bit k high means requester k wants or holds the resource.
- `o_gnt`  out  8  one-hot grant, registered; all zero when no owner.
- `o_gnt_idx`  out  3  index of the current or last owner, registered.
- `o_gnt_vld`  out  1  high while any grant is active; equals OR of `o_gnt`.
- `o_timeout`  out  1  one-cycle pulse when a grant is revoked by timeout. Tied to 0 when the feature is compiled out.
- `o_seg`  out  8  seven-segment pattern of `o_gnt_idx`, produced combinationally by `seg`.

## Operation
Internal state:
- Priority pointer `ptr` (3 bits).
- FSM with states IDLE and GRANT.
- Hold counter `hold_cnt`, present only when the feature is compiled in.

Arbitration function: among the candidate request bits, pick the first set bit searching upward from `ptr` and wrapping 7 → 0.

FSM behaviour:
- **IDLE:**
  - If `i_req` is nonzero, arbitrate, then register `o_gnt`, `o_gnt_idx` and `o_gnt_vld=1`, and move to GRANT.
  - Otherwise stay in IDLE with all outputs held.
- **GRANT, owner request high:** keep the grant. New requests from other requesters never preempt the owner.
- **GRANT, owner request low (release):**
  - Set `ptr = idx+1` (mod 8).
  - If another request is pending, arbitrate immediately, excluding the old owner. The new grant is registered next cycle with no idle gap.
  - Otherwise clear `o_gnt` and `o_gnt_vld` and go to IDLE. `o_gnt_idx` keeps the last owner.

Reset:
- Outputs: `o_gnt=0`, `o_gnt_idx=0`, `o_gnt_vld=0`, `o_timeout=0`.
- Internal: `ptr=0`, FSM in IDLE, `hold_cnt=0`.
- Reset asserted mid-grant revokes the grant on the next edge regardless of `i_req`.

Boundaries:
- **All eight requests high from reset:** grant order is 0, 1, 2, … 7, 0, …, with each owner rotating only on release (or timeout).
- **Wrap-around:** `ptr` wraps 7 → 0.
- **Owner drops its request and re-raises it in the same cycle that another bit rises:** the other requester wins, because the old owner is excluded from that arbitration.
- **Glitch-free grant:** `o_gnt` is never multi-hot.

## Timing
- **Grant latency:** request rises in cycle n while idle → `o_gnt` high in cycle n+1.
- **Release latency:** owner request falls in cycle m → old grant bit is low in cycle m+1. In the same cycle m+1, the next grant (if any request is pending) is high.
- `o_seg` follows `o_gnt_idx` combinationally, with no extra register.
- `o_timeout` is high for exactly the cycle in which the new grant first appears.

## Configuration
Macro: `RR_ARB_TIMEOUT_EN`.

**Defined:**
- `hold_cnt` has width $clog2(TIMEOUT+1). It clears on every new grant and increments each GRANT cycle while the owner's request stays high.
- When `hold_cnt == TIMEOUT`:
  - If another request is pending, the controller re-arbitrates excluding the owner, sets `ptr = idx+1`, switches the grant next cycle and pulses `o_timeout`.
  - If no other request is pending, the owner keeps the grant, `hold_cnt` clears, and no pulse is issued.

**Undefined:**
- There is no counter.
- The grant is held indefinitely while the owner's request stays high.
- `o_timeout` is constant 0.

## Structure
- **Shared package `rr_arb_pkg`:** the `N` and `IDX_W` constants, the FSM state encoding (IDLE=0, GRANT=1), and the default `TIMEOUT`.
- **Arbitration:** a combinational function (rotate-and-priority-encode) inside the block.
- **Sub-module:** one instance of the existing `seg` decoder, driven by `o_gnt_idx`.

## Test plan
- **Reset:** assert `i_rst` with `i_req=8'hFF` → all outputs 0, `o_seg` shows 0. On the first cycle after reset release, `o_gnt` is still 0; on the next edge `o_gnt=8'h01`.
- **Rotation:** hold `i_req=8'hFF`, then drop each owner's bit for one cycle → grant indices 0, 1, … 7, 0, with no gap cycles.
- **No preemption:** grant 5; raise bits 0 and 6 while bit 5 stays high → grant remains 8'h20. After releasing 5 → grant 8'h40 (6 is first after ptr=6).
- **Wrap and exclusion:** ptr=7; only bits 2 and 7 requesting, grant 7 released → `o_gnt=8'h04`, `o_gnt_idx=2`.
- **Timeout (macro on, TIMEOUT=4):** bits 1 and 3 held high, grant 1 → after 4 hold cycles `o_gnt=8'h08` with `o_timeout` pulsing once. With only bit 1 requesting, there is no switch and no pulse.
- **Reset mid-grant:** assert reset while `o_gnt=8'h10` → next cycle `o_gnt=0` and `o_gnt_idx=0`. After release, arbitration restarts from ptr=0.
